// File: rtl/emul_pkg.sv
// Shared constants for the elementwise-multiply job sequencer: lane count,
// FSM state encoding and the float constants used by the test bench.
package emul_pkg;

  localparam int LANES = 4;

  typedef logic [2:0] state_t;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_RD   = 3'd1;
  localparam logic [2:0] ST_OP   = 3'd2;
  localparam logic [2:0] ST_WR   = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  localparam logic [31:0] FP32_ONE = 32'h3F800000;
  localparam logic [31:0] FP32_TWO = 32'h40000000;

endpackage

// File: rtl/emul_lane_mask.sv
// Lane-enable mask for one word: all lanes on, except on the last word of a
// job whose element count is not a multiple of four.
module emul_lane_mask
  import emul_pkg::*;
(
  input  logic [1:0]       rem,
  input  logic             last,
  output logic [LANES-1:0] mask
);

  logic partial;

  assign partial = last && (rem != 2'd0);

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign mask[gi] = !partial || (2'(gi) < rem);
    end
  endgenerate

endmodule

// File: rtl/emul_job_ctrl.sv
// Job sequencer: reads operand words, feeds the external 4-lane multiplier
// and writes the masked products to result memory, one word per RD/OP/WR pass.
module emul_job_ctrl
  import emul_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int CNT_WIDTH  = ADDR_WIDTH + 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   a_base,
  input  logic [ADDR_WIDTH-1:0]   b_base,
  input  logic [ADDR_WIDTH-1:0]   r_base,
  input  logic [CNT_WIDTH-1:0]    elem_count,
  output logic                    rd_en,
  output logic [ADDR_WIDTH-1:0]   rd_addr_a,
  output logic [ADDR_WIDTH-1:0]   rd_addr_b,
  input  logic [4*DATA_WIDTH-1:0] rd_data_a,
  input  logic [4*DATA_WIDTH-1:0] rd_data_b,
  output logic [4*DATA_WIDTH-1:0] mul_a,
  output logic [4*DATA_WIDTH-1:0] mul_b,
  input  logic [4*DATA_WIDTH-1:0] mul_result,
  output logic                    wr_en,
  input  logic                    wr_ready,
  output logic [ADDR_WIDTH-1:0]   wr_addr,
  output logic [4*DATA_WIDTH-1:0] wr_data,
  output logic [3:0]              wr_lane_en,
  output logic                    busy,
  output logic                    done
);

  localparam int WW = LANES * DATA_WIDTH;

  state_t                  state_reg, state_next;
  logic [ADDR_WIDTH-1:0]   a_base_reg, b_base_reg, r_base_reg;
  logic [ADDR_WIDTH-1:0]   last_w_reg, w_reg;
  logic [1:0]              rem_reg;
  logic [WW-1:0]           mul_a_reg, mul_b_reg;
  logic [CNT_WIDTH-1:0]    count_m1;
  logic                    last_word;
  logic [LANES-1:0]        lane_mask;
  logic [WW-1:0]           lane_bits;
  logic                    accept;

  assign accept    = (state_reg == ST_IDLE) && start;
  assign count_m1  = elem_count - 1'b1;
  assign last_word = (w_reg == last_w_reg);

  emul_lane_mask u_lane_mask (
    .rem  (rem_reg),
    .last (last_word),
    .mask (lane_mask)
  );

  // Widen the per-lane mask to a full-word bit mask.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_bits
      assign lane_bits[gi*DATA_WIDTH +: DATA_WIDTH] = {DATA_WIDTH{lane_mask[gi]}};
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (start) state_next = (elem_count == '0) ? ST_DONE : ST_RD;
      ST_RD:   state_next = ST_OP;
      ST_OP:   state_next = ST_WR;
      ST_WR:   if (wr_ready) state_next = last_word ? ST_DONE : ST_RD;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      a_base_reg <= '0;
      b_base_reg <= '0;
      r_base_reg <= '0;
      last_w_reg <= '0;
      w_reg      <= '0;
      rem_reg    <= '0;
      mul_a_reg  <= '0;
      mul_b_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        a_base_reg <= a_base;
        b_base_reg <= b_base;
        r_base_reg <= r_base;
        // Index of the final word is (count-1)/4; unused for a zero count.
        last_w_reg <= count_m1[CNT_WIDTH-1:2];
        rem_reg    <= elem_count[1:0];
        w_reg      <= '0;
      end
      // Zeroing idle lanes at the operands keeps the multiplier output clean too.
      if (state_reg == ST_OP) begin
        mul_a_reg <= rd_data_a & lane_bits;
        mul_b_reg <= rd_data_b & lane_bits;
      end
      if ((state_reg == ST_WR) && wr_ready && !last_word) begin
        w_reg <= w_reg + 1'b1;
      end
    end
  end

  assign rd_en      = (state_reg == ST_RD);
  assign rd_addr_a  = rd_en ? a_base_reg + w_reg : '0;
  assign rd_addr_b  = rd_en ? b_base_reg + w_reg : '0;
  assign mul_a      = mul_a_reg;
  assign mul_b      = mul_b_reg;
  assign wr_en      = (state_reg == ST_WR);
  assign wr_addr    = wr_en ? r_base_reg + w_reg : '0;
  assign wr_data    = wr_en ? (mul_result & lane_bits) : '0;
  assign wr_lane_en = wr_en ? lane_mask : 4'h0;
  assign busy       = (state_reg != ST_IDLE);
  assign done       = (state_reg == ST_DONE);

endmodule

// File: tb/tb_emul_job_ctrl.sv
// Scoreboard bench for emul_job_ctrl with a behavioural operand RAM and a
// simple fp32 multiplier model standing in for the external multiplier.
module tb_emul_job_ctrl;
  import emul_pkg::*;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int CW = AW + 2;
  localparam int WW = 4 * DW;
  localparam logic [31:0] FP32_THREE = 32'h40400000;
  localparam logic [31:0] FP32_FOUR  = 32'h40800000;

  logic          clk = 1'b0;
  logic          rst_n, start, wr_ready;
  logic [AW-1:0] a_base, b_base, r_base;
  logic [CW-1:0] elem_count;
  logic          rd_en, wr_en, busy, done;
  logic [AW-1:0] rd_addr_a, rd_addr_b, wr_addr;
  logic [WW-1:0] rd_data_a, rd_data_b, mul_a, mul_b, mul_result, wr_data;
  logic [3:0]    wr_lane_en;

  emul_job_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a_base(a_base), .b_base(b_base), .r_base(r_base), .elem_count(elem_count),
    .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .mul_a(mul_a), .mul_b(mul_b), .mul_result(mul_result),
    .wr_en(wr_en), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_lane_en(wr_lane_en), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [WW-1:0] opmem [0:255];
  always @(posedge clk) begin
    if (rd_en) begin
      rd_data_a <= opmem[rd_addr_a];
      rd_data_b <= opmem[rd_addr_b];
    end
  end

  // Normal-number fp32 multiply with truncation; exact for the test operands.
  function automatic logic [31:0] fmul(input logic [31:0] x, input logic [31:0] y);
    logic [47:0] m;
    logic [9:0]  e;
    logic [22:0] f;
    if (x[30:23] == 8'd0 || y[30:23] == 8'd0) return {x[31] ^ y[31], 31'b0};
    m = 48'({1'b1, x[22:0]}) * 48'({1'b1, y[22:0]});
    e = 10'(x[30:23]) + 10'(y[30:23]) - 10'd127;
    if (m[47]) begin
      f = m[46:24];
      e = e + 10'd1;
    end else begin
      f = m[45:23];
    end
    return {x[31] ^ y[31], e[7:0], f};
  endfunction

  always_comb begin
    mul_result = '0;
    for (int i = 0; i < 4; i++)
      mul_result[i*DW +: DW] = fmul(mul_a[i*DW +: DW], mul_b[i*DW +: DW]);
  end

  function automatic logic [WW-1:0] word4(input logic [31:0] l0, l1, l2, l3);
    return {l3, l2, l1, l0};
  endfunction

  typedef struct {
    logic [AW-1:0] addr;
    logic [WW-1:0] data;
    logic [3:0]    lane_en;
  } wr_t;

  wr_t exp_q[$];
  int  total = 0;
  int  bad = 0;

  logic [AW-1:0] rd_a_log[$], rd_b_log[$], wr_addr_log[$];
  logic [WW-1:0] mula_log[$], mulb_log[$];
  int   done_cyc, busy_cyc, done_pulses, stall_seen;
  logic busy_after, hold_ok, rd_in_stall, both_en, zero_ok, aborted;
  logic [AW-1:0] held_addr;
  logic [WW-1:0] held_data;
  logic [3:0]    held_lane;

  function automatic void push_exp(input logic [AW-1:0] a, input logic [WW-1:0] d,
                                   input logic [3:0] l);
    wr_t e;
    e.addr = a; e.data = d; e.lane_en = l;
    exp_q.push_back(e);
  endfunction

  // Runs one job, popping the scoreboard on each accepted write.
  // inj_kind 1 pulses start with new bases at cycle inj_cyc; 2 asserts reset there.
  task automatic run_job(input logic [AW-1:0] a, b, r, input logic [CW-1:0] cnt,
                         input int stall, input int inj_cyc, input int inj_kind);
    wr_t  e;
    logic wr_prev = 1'b0;
    rd_a_log.delete(); rd_b_log.delete(); wr_addr_log.delete();
    mula_log.delete(); mulb_log.delete();
    done_cyc = -1; busy_cyc = 0; done_pulses = 0; stall_seen = 0;
    busy_after = 1'b1; hold_ok = 1'b1; rd_in_stall = 1'b0; both_en = 1'b0;
    zero_ok = 1'b0; aborted = 1'b0;
    a_base = a; b_base = b; r_base = r; elem_count = cnt;
    wr_ready = (stall == 0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      start = (inj_kind == 1) && (cyc == inj_cyc);
      if (start) begin
        a_base = 8'hA0; b_base = 8'hB0; r_base = 8'hC0; elem_count = 10'd4;
      end
      if ((inj_kind == 2) && (cyc == inj_cyc)) begin
        rst_n = 1'b0;
        #1;
        zero_ok = ({rd_en, wr_en, busy, done, wr_lane_en} == 8'd0) && (rd_addr_a == '0) &&
                  (rd_addr_b == '0) && (wr_addr == '0) && (wr_data == '0) &&
                  (mul_a == '0) && (mul_b == '0);
        aborted = 1'b1;
        break;
      end
      if (rd_en) begin
        rd_a_log.push_back(rd_addr_a);
        rd_b_log.push_back(rd_addr_b);
      end
      if (rd_en && wr_en) both_en = 1'b1;
      if (wr_en && !wr_prev) begin
        wr_addr_log.push_back(wr_addr);
        mula_log.push_back(mul_a);
        mulb_log.push_back(mul_b);
      end
      wr_prev = wr_en;
      if (wr_en && stall_seen < stall) begin
        if (stall_seen == 0) begin
          held_addr = wr_addr; held_data = wr_data; held_lane = wr_lane_en;
        end else if (wr_addr !== held_addr || wr_data !== held_data || wr_lane_en !== held_lane) begin
          hold_ok = 1'b0;
        end
        stall_seen++;
      end else if (wr_en && stall > 0 && stall_seen == stall) begin
        wr_ready = 1'b1;
      end
      if (stall_seen > 0 && !wr_ready && rd_en) rd_in_stall = 1'b1;
      if (wr_en && wr_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL sb_unexpected_write: got addr=%0d data=%h lane=%b, required no write",
                   wr_addr, wr_data, wr_lane_en);
        end else begin
          e = exp_q.pop_front();
          if (wr_addr !== e.addr || wr_data !== e.data || wr_lane_en !== e.lane_en) begin
            bad++;
            $display("FAIL sb_write: got addr=%0d data=%h lane=%b, required addr=%0d data=%h lane=%b",
                     wr_addr, wr_data, wr_lane_en, e.addr, e.data, e.lane_en);
          end
        end
      end
      if (busy) busy_cyc++;
      if (done) begin
        done_pulses++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done_cyc >= 0 && cyc == done_cyc + 1) begin
        busy_after = busy;
        break;
      end
      @(posedge clk); #1;
    end
    wr_ready = 1'b1;
    if (!aborted && done_cyc < 0) begin
      total++; bad++;
      $display("FAIL job_timeout: got no done within 400 cycles, required done");
    end
    $display("job a=%0d b=%0d r=%0d cnt=%0d stall=%0d: done_cyc=%0d busy_cyc=%0d rd=%0d wr=%0d",
             a, b, r, cnt, stall, done_cyc, busy_cyc, rd_a_log.size(), wr_addr_log.size());
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({rd_en, wr_en, busy, done, wr_lane_en} !== 8'd0) begin
      bad++;
      $display("FAIL reset_ctrl: got rd=%b wr=%b busy=%b done=%b lane=%b, required all 0",
               rd_en, wr_en, busy, done, wr_lane_en);
    end
    total++;
    if ({mul_a, mul_b, wr_data} !== '0 || {rd_addr_a, rd_addr_b, wr_addr} !== '0) begin
      bad++;
      $display("FAIL reset_data: got mul_a=%h mul_b=%h wr_data=%h, required 0", mul_a, mul_b, wr_data);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_full_words();
    push_exp(8'd32, word4(32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000), 4'hF);
    push_exp(8'd33, word4(FP32_TWO, FP32_TWO, FP32_TWO, FP32_TWO), 4'hF);
    run_job(8'd0, 8'd16, 8'd32, 10'd8, 0, 0, 0);
    total++;
    if (done_cyc !== 7 || done_pulses !== 1) begin
      bad++;
      $display("FAIL full_done: got cyc=%0d pulses=%0d, required cyc=7 pulses=1", done_cyc, done_pulses);
    end
    total++;
    if (busy_cyc !== 7 || busy_after !== 1'b0) begin
      bad++;
      $display("FAIL full_busy: got cycles=%0d after=%b, required cycles=7 after=0", busy_cyc, busy_after);
    end
    total++;
    if (rd_a_log.size() != 2 || rd_a_log[0] !== 8'd0 || rd_a_log[1] !== 8'd1 ||
        rd_b_log[0] !== 8'd16 || rd_b_log[1] !== 8'd17) begin
      bad++;
      $display("FAIL full_rd_addr: got %0d reads, required a=0,1 b=16,17", rd_a_log.size());
    end
    total++;
    if (exp_q.size() != 0 || both_en !== 1'b0) begin
      bad++;
      $display("FAIL full_drain: got pending=%0d overlap=%b, required 0 0", exp_q.size(), both_en);
    end
  endtask

  task automatic test_partial_tail();
    logic [WW-1:0] ma, mb;
    push_exp(8'd32, word4(32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000), 4'hF);
    push_exp(8'd33, word4(FP32_TWO, FP32_TWO, 32'h0, 32'h0), 4'b0011);
    run_job(8'd0, 8'd16, 8'd32, 10'd6, 0, 0, 0);
    ma = (mula_log.size() > 1) ? mula_log[1] : '1;
    mb = (mulb_log.size() > 1) ? mulb_log[1] : '1;
    total++;
    if (ma !== word4(FP32_ONE, FP32_ONE, 32'h0, 32'h0) || mb !== word4(FP32_TWO, FP32_TWO, 32'h0, 32'h0)) begin
      bad++;
      $display("FAIL tail_operands: got mul_a=%h mul_b=%h, required lanes 2-3 zero", ma, mb);
    end
    total++;
    if (done_cyc !== 7 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL tail_done: got cyc=%0d pending=%0d, required 7 0", done_cyc, exp_q.size());
    end
  endtask

  task automatic test_back_pressure();
    push_exp(8'd32, word4(32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000), 4'hF);
    push_exp(8'd33, word4(FP32_TWO, FP32_TWO, FP32_TWO, FP32_TWO), 4'hF);
    run_job(8'd0, 8'd16, 8'd32, 10'd8, 5, 0, 0);
    total++;
    if (hold_ok !== 1'b1 || stall_seen !== 5 || rd_in_stall !== 1'b0) begin
      bad++;
      $display("FAIL bp_hold: got hold=%b stalls=%0d rd_in_stall=%b, required 1 5 0",
               hold_ok, stall_seen, rd_in_stall);
    end
    total++;
    if (done_cyc !== 12 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL bp_done: got cyc=%0d pending=%0d, required 12 0", done_cyc, exp_q.size());
    end
  endtask

  task automatic test_zero_length();
    run_job(8'd0, 8'd16, 8'd32, 10'd0, 0, 0, 0);
    total++;
    if (done_cyc !== 1 || busy_cyc !== 1 || busy_after !== 1'b0) begin
      bad++;
      $display("FAIL zero_timing: got done=%0d busy=%0d after=%b, required 1 1 0",
               done_cyc, busy_cyc, busy_after);
    end
    total++;
    if (rd_a_log.size() != 0 || wr_addr_log.size() != 0) begin
      bad++;
      $display("FAIL zero_access: got rd=%0d wr=%0d, required 0 0", rd_a_log.size(), wr_addr_log.size());
    end
  endtask

  task automatic test_start_while_busy();
    push_exp(8'd32, word4(32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000), 4'hF);
    push_exp(8'd33, word4(FP32_TWO, FP32_TWO, FP32_TWO, FP32_TWO), 4'hF);
    run_job(8'd0, 8'd16, 8'd32, 10'd8, 0, 2, 1);
    total++;
    if (rd_a_log.size() != 2 || rd_a_log[1] !== 8'd1 || rd_b_log[1] !== 8'd17 ||
        wr_addr_log.size() != 2 || wr_addr_log[1] !== 8'd33) begin
      bad++;
      $display("FAIL busy_start_addr: got rd=%0d wr=%0d, required original bases", rd_a_log.size(),
               wr_addr_log.size());
    end
    total++;
    if (done_cyc !== 7 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL busy_start_done: got cyc=%0d pending=%0d, required 7 0", done_cyc, exp_q.size());
    end
  endtask

  task automatic test_reset_mid_job();
    int writes = 0;
    run_job(8'd0, 8'd16, 8'd32, 10'd8, 0, 2, 2);
    total++;
    if (zero_ok !== 1'b1) begin
      bad++;
      $display("FAIL abort_outputs: got nonzero outputs (wr_en=%b mul_a=%h), required all 0", wr_en, mul_a);
    end
    repeat (3) begin
      @(posedge clk); #1;
      if (wr_en) writes++;
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (writes != 0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL abort_quiet: got writes=%0d busy=%b, required 0 0", writes, busy);
    end
    push_exp(8'd32, word4(32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000), 4'hF);
    push_exp(8'd33, word4(FP32_TWO, FP32_TWO, FP32_TWO, FP32_TWO), 4'hF);
    run_job(8'd0, 8'd16, 8'd32, 10'd8, 0, 0, 0);
    total++;
    if (done_cyc !== 7 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL abort_fresh: got cyc=%0d pending=%0d, required 7 0", done_cyc, exp_q.size());
    end
  endtask

  task automatic test_addr_wrap();
    push_exp(8'd255, word4(FP32_TWO, FP32_TWO, FP32_TWO, FP32_TWO), 4'hF);
    push_exp(8'd0, word4(32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000), 4'hF);
    run_job(8'd255, 8'd16, 8'd255, 10'd8, 0, 0, 0);
    total++;
    if (rd_a_log.size() != 2 || rd_a_log[0] !== 8'd255 || rd_a_log[1] !== 8'd0) begin
      bad++;
      $display("FAIL wrap_rd: got %0d reads, required a=255,0", rd_a_log.size());
    end
    total++;
    if (wr_addr_log.size() != 2 || wr_addr_log[0] !== 8'd255 || wr_addr_log[1] !== 8'd0 ||
        exp_q.size() != 0) begin
      bad++;
      $display("FAIL wrap_wr: got %0d writes pending=%0d, required wr=255,0", wr_addr_log.size(),
               exp_q.size());
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; wr_ready = 1'b1;
    a_base = '0; b_base = '0; r_base = '0; elem_count = '0;
    rd_data_a = '0; rd_data_b = '0;
    for (int i = 0; i < 256; i++) opmem[i] = '0;
    opmem[0]   = word4(FP32_ONE, FP32_TWO, FP32_THREE, FP32_FOUR);
    opmem[1]   = word4(FP32_ONE, FP32_ONE, FP32_ONE, FP32_ONE);
    opmem[16]  = word4(FP32_TWO, FP32_TWO, FP32_TWO, FP32_TWO);
    opmem[17]  = word4(FP32_TWO, FP32_TWO, FP32_TWO, FP32_TWO);
    opmem[255] = word4(FP32_ONE, FP32_ONE, FP32_ONE, FP32_ONE);
    test_reset();
    test_full_words();
    test_partial_tail();
    test_back_pressure();
    test_zero_length();
    test_start_while_busy();
    test_reset_mid_job();
    test_addr_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
